mprj_io_serial_loader: RTL and testbench
========================================

MPRJ_IO_SERIAL_LOADER -- requirements
Module: mprj_io_serial_loader

Purpose: sequences transfer of per-pad user I/O configuration words from the mprj control register file into the serial chain of pad control blocks, then strobes load.

Interface
REQ-001 Parameter IO_PADS, default 38, number of configuration words (pads) in the chain; range 1..64.
REQ-002 Parameter CFG_BITS, default 13, width of each pad configuration word; range 1..16.
REQ-003 Parameter CLK_DIV, default 2, duration of each serial clock phase in wb_clk_i cycles; minimum 1.
REQ-004 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 xfer_start  input  1  request a full chain transfer; sampled each cycle.
REQ-007 cfg_raddr  output  6  register-file word index being fetched.
REQ-008 cfg_rdata  input  CFG_BITS  configuration word; combinationally valid for cfg_raddr in the same cycle.
REQ-009 serial_clock  output  1  chain shift clock.
REQ-010 serial_data_out  output  1  chain shift data.
REQ-011 serial_load  output  1  chain load strobe.
REQ-012 serial_resetn  output  1  chain reset, active-low.
REQ-013 busy  output  1  high while a transfer is in progress.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, FETCH, SHIFT_LO, SHIFT_HI and LOAD; all outputs SHALL be registered.
REQ-016 In IDLE with xfer_start=1: next state FETCH, busy=1, cfg_raddr=IO_PADS-1, bit counter=CFG_BITS-1.
REQ-017 In IDLE with xfer_start=0, and in any state other than IDLE, xfer_start SHALL be ignored; no request is queued.
REQ-018 FETCH SHALL last exactly 1 cycle, capture cfg_rdata into the shift register, then enter SHIFT_LO.
REQ-019 SHIFT_LO: serial_clock=0, serial_data_out=current shift-register MSB (bit CFG_BITS-1), held CLK_DIV cycles; then SHIFT_HI.
REQ-020 SHIFT_HI: serial_clock=1, serial_data_out unchanged, held CLK_DIV cycles; serial_data_out SHALL change only on entry to SHIFT_LO.
REQ-021 At the end of SHIFT_HI: if bits remain, shift left by 1, decrement the bit counter and enter SHIFT_LO.
REQ-022 At the end of SHIFT_HI after the last bit: if cfg_raddr>0, decrement cfg_raddr and enter FETCH; if cfg_raddr=0, enter LOAD.
REQ-023 Word order SHALL be index IO_PADS-1 down to 0, MSB first within each word, so that word 0 reaches the nearest pad.
REQ-024 LOAD: serial_clock=0, serial_load=1 for CLK_DIV cycles; then enter IDLE with serial_load=0, busy=0 and done=1 for exactly 1 cycle.
REQ-025 Timing: xfer_start sampled at edge 0 -> done=1 in the cycle after edge N, with N = IO_PADS*(1+2*CLK_DIV*CFG_BITS)+CLK_DIV (2016 at defaults); busy is high for exactly N cycles.
REQ-026 xfer_start=1 in the done cycle SHALL be accepted (state is IDLE), giving back-to-back transfers spaced N+1 cycles apart.
REQ-027 The shift counter and word counter SHALL NOT wrap: the word index never goes below 0 and never exceeds IO_PADS-1.

Reset
REQ-028 While wb_rst_i=1: state IDLE, cfg_raddr=0, serial_clock=0, serial_data_out=0, serial_load=0, busy=0, done=0, serial_resetn=0.
REQ-029 serial_resetn SHALL go to 1 on the first edge with wb_rst_i=0 and stay 1 until the next reset.
REQ-030 A reset during any state SHALL abort the transfer on that edge, with no serial_load or done pulse.
REQ-031 After an abort, the next xfer_start SHALL restart from word IO_PADS-1.

Verification
REQ-032 Defaults, cfg_rdata={7'b0,cfg_raddr}, one xfer_start pulse -> a chain model clocked on serial_clock rising edges holds word k=k for k=0..37 at serial_load; done at cycle 2016; busy high for 2016 cycles.
REQ-033 IO_PADS=2, CFG_BITS=4, CLK_DIV=1, words 4'hA (addr 1) and 4'h5 (addr 0) -> serial_data_out sequence 1,0,1,0,0,1,0,1; serial_clock high 1 cycle per bit; serial_load high 1 cycle; done at cycle 19.
REQ-034 Defaults, xfer_start pulsed again at cycles 10 and 1000 -> ignored; exactly one done pulse, at cycle 2016.
REQ-035 Defaults, xfer_start held high -> done pulses at cycles 2016, 4033 and 6050; busy low only during the done cycles.
REQ-036 Reset asserted at cycle 500 mid-shift -> all outputs take reset values on the next edge, no serial_load or done pulse; a new start gives done 2016 cycles later.
REQ-037 Power-on: wb_rst_i high for 5 cycles -> serial_resetn=0 throughout; serial_resetn=1 after the first edge with wb_rst_i low.

Source files
------------

// File: rtl/mprj_io_serial_loader.sv
// Serial loader for the user-project pad control chain: walks the config register file from the
// last pad down to pad 0, shifts each word MSB first, then pulses load.
module mprj_io_serial_loader #(
    parameter int unsigned IO_PADS  = 38,
    parameter int unsigned CFG_BITS = 13,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                xfer_start,
    output logic [5:0]          cfg_raddr,
    input  logic [CFG_BITS-1:0] cfg_rdata,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [5:0]    LastAddr = 6'(IO_PADS - 1);
    localparam logic [BW-1:0] LastBit  = BW'(CFG_BITS - 1);
    localparam logic [DW-1:0] DivLoad  = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StShiftLo, StShiftHi, StLoad} state_e;

    state_e              r_state, w_state;
    logic [5:0]          r_raddr, w_raddr;
    logic [BW-1:0]       r_bit, w_bit;
    logic [DW-1:0]       r_div, w_div;
    logic [CFG_BITS-1:0] r_shift, w_shift;
    logic                r_sclk, w_sclk;
    logic                r_sdo, w_sdo;
    logic                r_load, w_load;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_resetn;
    logic [CFG_BITS-1:0] w_shifted;

    assign w_shifted = r_shift << 1;

    always_comb begin
        w_state = r_state;
        w_raddr = r_raddr;
        w_bit   = r_bit;
        w_div   = r_div;
        w_shift = r_shift;
        w_sclk  = r_sclk;
        w_sdo   = r_sdo;
        w_load  = r_load;
        w_busy  = r_busy;
        w_done  = 1'b0;
        case (r_state)
            StIdle: begin
                if (xfer_start) begin
                    w_state = StFetch;
                    w_busy  = 1'b1;
                    w_raddr = LastAddr;
                    w_bit   = LastBit;
                end
            end
            StFetch: begin
                w_shift = cfg_rdata;
                w_sdo   = cfg_rdata[CFG_BITS-1];
                w_sclk  = 1'b0;
                w_div   = DivLoad;
                w_state = StShiftLo;
            end
            StShiftLo: begin
                if (r_div == '0) begin
                    w_state = StShiftHi;
                    w_sclk  = 1'b1;
                    w_div   = DivLoad;
                end else begin
                    w_div = r_div - 1'b1;
                end
            end
            StShiftHi: begin
                if (r_div != '0) begin
                    w_div = r_div - 1'b1;
                end else begin
                    w_sclk = 1'b0;
                    w_div  = DivLoad;
                    if (r_bit != '0) begin
                        // Data only moves on entry to the low phase, never mid-bit.
                        w_shift = w_shifted;
                        w_sdo   = w_shifted[CFG_BITS-1];
                        w_bit   = r_bit - 1'b1;
                        w_state = StShiftLo;
                    end else if (r_raddr != '0) begin
                        w_raddr = r_raddr - 1'b1;
                        w_bit   = LastBit;
                        w_state = StFetch;
                    end else begin
                        w_load  = 1'b1;
                        w_state = StLoad;
                    end
                end
            end
            StLoad: begin
                if (r_div == '0) begin
                    w_load  = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = StIdle;
                end else begin
                    w_div = r_div - 1'b1;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= StIdle;
            r_raddr  <= '0;
            r_bit    <= '0;
            r_div    <= '0;
            r_shift  <= '0;
            r_sclk   <= 1'b0;
            r_sdo    <= 1'b0;
            r_load   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_resetn <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_raddr  <= w_raddr;
            r_bit    <= w_bit;
            r_div    <= w_div;
            r_shift  <= w_shift;
            r_sclk   <= w_sclk;
            r_sdo    <= w_sdo;
            r_load   <= w_load;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_resetn <= 1'b1;
        end
    end

    assign cfg_raddr       = r_raddr;
    assign serial_clock    = r_sclk;
    assign serial_data_out = r_sdo;
    assign serial_load     = r_load;
    assign serial_resetn   = r_resetn;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Bench for mprj_io_serial_loader: a small instance checked cycle by cycle from a vector table,
// and a default instance checked for timing, request handling, abort and chain contents.
module tb_mprj_io_serial_loader;

    localparam int Pads  = 38;
    localparam int Bits  = 13;
    localparam int NCyc  = 2016;

    logic clk, rst;

    // Default-parameter instance.
    logic            d_start;
    logic [5:0]      d_raddr;
    logic [Bits-1:0] d_rdata;
    logic            d_sclk, d_sdo, d_load, d_resetn, d_busy, d_done;

    // Small instance: IO_PADS=2, CFG_BITS=4, CLK_DIV=1.
    logic       s_start;
    logic [5:0] s_raddr;
    logic [3:0] s_rdata;
    logic       s_sclk, s_sdo, s_load, s_resetn, s_busy, s_done;

    assign d_rdata = {7'b0, d_raddr};
    assign s_rdata = (s_raddr == 6'd1) ? 4'hA : 4'h5;

    mprj_io_serial_loader u_dflt (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .xfer_start      (d_start),
        .cfg_raddr       (d_raddr),
        .cfg_rdata       (d_rdata),
        .serial_clock    (d_sclk),
        .serial_data_out (d_sdo),
        .serial_load     (d_load),
        .serial_resetn   (d_resetn),
        .busy            (d_busy),
        .done            (d_done)
    );

    mprj_io_serial_loader #(
        .IO_PADS  (2),
        .CFG_BITS (4),
        .CLK_DIV  (1)
    ) u_small (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .xfer_start      (s_start),
        .cfg_raddr       (s_raddr),
        .cfg_rdata       (s_rdata),
        .serial_clock    (s_sclk),
        .serial_data_out (s_sdo),
        .serial_load     (s_load),
        .serial_resetn   (s_resetn),
        .busy            (s_busy),
        .done            (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: bits enter at the near end on each serial_clock rise.
    logic [Pads*Bits-1:0] chain;
    logic [Pads*Bits-1:0] snap;
    int                   snap_cnt = 0;
    initial chain = '0;
    always @(posedge d_sclk) chain <= {chain[Pads*Bits-2:0], d_sdo};
    always @(posedge d_load) begin
        snap = chain;
        snap_cnt++;
    end

    int checks   = 0;
    int failures = 0;
    int busy_cnt, load_cnt;
    int done_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_dflt(input int ncyc, input int p0, input int p1, input int p2,
                            input bit hold);
        done_q.delete();
        busy_cnt = 0;
        load_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            d_start = hold || (c == p0) || (c == p1) || (c == p2);
            @(posedge clk);
            #1;
            if (d_busy) busy_cnt++;
            if (d_load) load_cnt++;
            if (d_done) done_q.push_back(c);
        end
        d_start = 1'b0;
    endtask

    task automatic check_chain(input string tag);
        for (int k = 0; k < Pads; k++)
            check($sformatf("%s_word%0d", tag, k), longint'(snap[k*Bits +: Bits]), longint'(k));
    endtask

    typedef struct packed {
        logic       start;
        logic [5:0] raddr;
        logic       sclk;
        logic       sdo;
        logic       load;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[21];

    initial begin
        int snap0;

        // Expected small-instance outputs #1 after edge i; start drives edge i.
        vecs[0]  = {1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = {1'b0, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = {1'b0, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = {1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = {1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = {1'b0, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = {1'b0, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = {1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = {1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = {1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = {1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = {1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = {1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = {1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = {1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = {1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = {1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[17] = {1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[18] = {1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[19] = {1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[20] = {1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        d_start = 1'b0;
        s_start = 1'b0;
        rst     = 1'b1;

        // Power-on reset: every output at its reset value, serial_resetn low throughout.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("por_outputs_c%0d", i),
                  longint'({d_raddr, d_sclk, d_sdo, d_load, d_busy, d_done, d_resetn}), 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resetn_release_dflt", longint'(d_resetn), 1);
        check("resetn_release_small", longint'(s_resetn), 1);

        // Small instance, cycle-accurate table.
        for (int i = 0; i < 21; i++) begin
            s_start = vecs[i].start;
            @(posedge clk);
            #1;
            check($sformatf("small_e%0d", i),
                  longint'({s_raddr, s_sclk, s_sdo, s_load, s_busy, s_done}),
                  longint'({vecs[i].raddr, vecs[i].sclk, vecs[i].sdo, vecs[i].load,
                            vecs[i].busy, vecs[i].done}));
        end
        s_start = 1'b0;

        // Single transfer with ignored mid-transfer requests.
        snap0 = snap_cnt;
        run_dflt(2030, 0, 10, 1000, 1'b0);
        check("single_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("single_done_cycle", done_q[0], NCyc);
        check("single_busy_cycles", busy_cnt, NCyc);
        check("single_load_cycles", load_cnt, 2);
        check("single_load_pulses", snap_cnt - snap0, 1);
        check_chain("single");

        // Start held high: back-to-back transfers spaced N+1 apart.
        do_reset(2);
        run_dflt(6051, -1, -1, -1, 1'b1);
        check("hold_done_count", done_q.size(), 3);
        if (done_q.size() > 2) begin
            check("hold_done0", done_q[0], 2016);
            check("hold_done1", done_q[1], 4033);
            check("hold_done2", done_q[2], 6050);
        end
        check("hold_busy_low_cycles", 6051 - busy_cnt, 3);

        // Abort mid-shift, then restart from the last word.
        do_reset(2);
        snap0 = snap_cnt;
        run_dflt(500, 0, -1, -1, 1'b0);
        check("abort_pre_busy", longint'(d_busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs",
              longint'({d_raddr, d_sclk, d_sdo, d_load, d_busy, d_done, d_resetn}), 0);
        rst = 1'b0;
        run_dflt(40, -1, -1, -1, 1'b0);
        check("abort_no_done", done_q.size(), 0);
        check("abort_no_load", load_cnt, 0);
        check("abort_no_load_pulse", snap_cnt - snap0, 0);
        check("abort_idle_busy", busy_cnt, 0);
        run_dflt(2030, 3, -1, -1, 1'b0);
        check("restart_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("restart_done_cycle", done_q[0], 3 + NCyc);
        check("restart_busy_cycles", busy_cnt, NCyc);
        check("restart_load_pulses", snap_cnt - snap0, 1);
        check_chain("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
